mux_rr_arbiter: RTL and testbench

//   Round-robin arbiter that shares one N:1 data mux (mux8 / mux4 tree) among N_REQ requesters.

---
 rtl/mux_arb_pkg.sv | 18 +
 rtl/rr_pick.sv | 34 +++
 rtl/mux_rr_arbiter.sv | 122 ++++++++++++
 tb/tb_mux_rr_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// rtl/mux_arb_pkg.sv - shared types and constants for the round-robin mux arbiter
package mux_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_GRANT,
    ARB_GAP
  } arb_state_t;

  localparam int ARB_MAX_REQ  = 8;
  localparam int ARB_DEF_HOLD = 16;

  // Folds an index that may have run one lap past n back into 0..n-1.
  function automatic int rr_wrap(input int v, input int n);
    return (v >= n) ? v - n : v;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotate-priority encoder: first set req at ptr, ptr+1, ... wrapping
module rr_pick
  import mux_arb_pkg::*;
#(
  parameter int N_REQ = ARB_MAX_REQ,
  parameter int SEL_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             any,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] cand [N_REQ];

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      cand[i] = SEL_W'(rr_wrap(int'(ptr) + i, N_REQ));
    end
  end

  // Scan from lowest priority to highest so the last hit is the winner.
  always_comb begin
    any = 1'b0;
    idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[cand[i]]) begin
        any = 1'b1;
        idx = cand[i];
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - round-robin owner of a shared N:1 mux with break-before-make handover
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int N_REQ    = ARB_MAX_REQ,
  parameter int SEL_W    = $clog2(N_REQ),
  parameter int MAX_HOLD = ARB_DEF_HOLD,
  parameter int CNT_W    = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic [SEL_W-1:0] sel,
  output logic             sel_valid,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam logic [N_REQ-1:0] ONE_HOT0  = N_REQ'(1);
  localparam logic [SEL_W-1:0] LAST_IDX  = SEL_W'(N_REQ - 1);

  arb_state_t       state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;

  logic             pick_any;
  logic [SEL_W-1:0] pick_idx;
  logic             owner_req;
  logic             hold_at_limit;
  logic [SEL_W-1:0] ptr_after_owner;

  rr_pick #(
    .N_REQ (N_REQ),
    .SEL_W (SEL_W)
  ) u_pick (
    .req (req),
    .ptr (ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign owner_req       = req[sel_q];
  assign hold_at_limit   = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);
  assign ptr_after_owner = (sel_q == LAST_IDX) ? '0 : sel_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    grant_d   = grant_q;
    sel_d     = sel_q;
    valid_d   = valid_q;
    timeout_d = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        if (en && pick_any) begin
          state_d = ARB_GRANT;
          grant_d = ONE_HOT0 << pick_idx;
          sel_d   = pick_idx;
          valid_d = 1'b1;
          hold_d  = '0;
        end
      end

      ARB_GRANT: begin
        // A voluntary release in the limit cycle wins over the timeout.
        if (!owner_req || hold_at_limit) begin
          state_d   = ARB_GAP;
          grant_d   = '0;
          valid_d   = 1'b0;
          ptr_d     = ptr_after_owner;
          timeout_d = owner_req;
        end else if (hold_q != '1) begin
          hold_d = hold_q + 1'b1;
        end
      end

      ARB_GAP: begin
        state_d = ARB_IDLE;
      end

      default: begin
        state_d = ARB_IDLE;
        grant_d = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ARB_IDLE;
      ptr_q     <= '0;
      hold_q    <= '0;
      grant_q   <= '0;
      sel_q     <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      grant_q   <= grant_d;
      sel_q     <= sel_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  assign grant     = grant_q;
  assign sel       = sel_q;
  assign sel_valid = valid_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb/tb_mux_rr_arbiter.sv - scoreboard bench for mux_rr_arbiter (N_REQ=8, MAX_HOLD=4)
module tb_mux_rr_arbiter;

  typedef struct packed {
    logic [7:0] grant;
    logic [2:0] sel;
    logic       valid;
    logic       to;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [7:0] req = 8'h00;
  logic [7:0] grant;
  logic [2:0] sel;
  logic       sel_valid;
  logic       timeout;

  int   checks = 0;
  int   errors = 0;
  obs_t exp_q[$];

  mux_rr_arbiter #(
    .N_REQ    (8),
    .MAX_HOLD (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req       (req),
    .grant     (grant),
    .sel       (sel),
    .sel_valid (sel_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  function automatic obs_t mk(input logic [7:0] g, input logic [2:0] s, input logic v, input logic t);
    obs_t o;
    o.grant = g;
    o.sel   = s;
    o.valid = v;
    o.to    = t;
    return o;
  endfunction

  function automatic obs_t observe();
    return mk(grant, sel, sel_valid, timeout);
  endfunction

  // Inputs change on the falling edge; outputs are read one falling edge later.
  task automatic step(input logic [7:0] r, input logic e);
    req = r;
    en  = e;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = 8'h00;
    en    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    obs_t act, ex;
    do_reset();
    checks++;
    act = observe();
    if (act !== mk(8'h00, 3'd0, 1'b0, 1'b0)) begin
      errors++;
      $display("FAIL reset_state: got grant=%h sel=%0d valid=%b timeout=%b, expected all zero",
               act.grant, act.sel, act.valid, act.to);
    end
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(mk(8'h00, 3'd0, 1'b0, 1'b0));
      step(8'h00, 1'b1);
      act = observe();
      ex  = exp_q.pop_front();
      checks++;
      if (act !== ex) begin
        errors++;
        $display("FAIL idle_no_req step %0d: got grant=%h sel=%0d valid=%b timeout=%b, expected grant=%h sel=%0d valid=%b timeout=%b",
                 i, act.grant, act.sel, act.valid, act.to, ex.grant, ex.sel, ex.valid, ex.to);
      end
    end
  endtask

  task automatic test_single_owner();
    logic [7:0] r [8];
    obs_t       x [8];
    obs_t       act, ex;
    do_reset();
    r = '{8'h01, 8'h01, 8'h01, 8'h00, 8'h03, 8'h03, 8'h00, 8'h00};
    x = '{mk(8'h01, 3'd0, 1'b1, 1'b0), mk(8'h01, 3'd0, 1'b1, 1'b0), mk(8'h01, 3'd0, 1'b1, 1'b0),
          mk(8'h00, 3'd0, 1'b0, 1'b0), mk(8'h00, 3'd0, 1'b0, 1'b0), mk(8'h02, 3'd1, 1'b1, 1'b0),
          mk(8'h00, 3'd1, 1'b0, 1'b0), mk(8'h00, 3'd1, 1'b0, 1'b0)};
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(x[i]);
      step(r[i], 1'b1);
      act = observe();
      ex  = exp_q.pop_front();
      checks++;
      if (act !== ex) begin
        errors++;
        $display("FAIL single_owner step %0d: got grant=%h sel=%0d valid=%b timeout=%b, expected grant=%h sel=%0d valid=%b timeout=%b",
                 i, act.grant, act.sel, act.valid, act.to, ex.grant, ex.sel, ex.valid, ex.to);
      end
    end
  endtask

  task automatic test_timeout_alternate();
    obs_t act, ex;
    int   phase;
    logic [2:0] owner;
    do_reset();
    for (int s = 0; s < 24; s++) begin
      phase = s % 6;
      owner = ((s / 6) % 2 == 0) ? 3'd0 : 3'd7;
      if (phase < 4)
        exp_q.push_back(mk(8'h01 << owner, owner, 1'b1, 1'b0));
      else
        exp_q.push_back(mk(8'h00, owner, 1'b0, phase == 4));
      step(8'h81, 1'b1);
      act = observe();
      ex  = exp_q.pop_front();
      checks++;
      if (act !== ex) begin
        errors++;
        $display("FAIL timeout_alternate step %0d: got grant=%h sel=%0d valid=%b timeout=%b, expected grant=%h sel=%0d valid=%b timeout=%b",
                 s, act.grant, act.sel, act.valid, act.to, ex.grant, ex.sel, ex.valid, ex.to);
      end
    end
  endtask

  task automatic test_release_at_limit();
    logic [7:0] r [6];
    obs_t       x [6];
    obs_t       act, ex;
    do_reset();
    r = '{8'h10, 8'h10, 8'h10, 8'h10, 8'h00, 8'h00};
    x = '{mk(8'h10, 3'd4, 1'b1, 1'b0), mk(8'h10, 3'd4, 1'b1, 1'b0), mk(8'h10, 3'd4, 1'b1, 1'b0),
          mk(8'h10, 3'd4, 1'b1, 1'b0), mk(8'h00, 3'd4, 1'b0, 1'b0), mk(8'h00, 3'd4, 1'b0, 1'b0)};
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(x[i]);
      step(r[i], 1'b1);
      act = observe();
      ex  = exp_q.pop_front();
      checks++;
      if (act !== ex) begin
        errors++;
        $display("FAIL release_at_limit step %0d: got grant=%h sel=%0d valid=%b timeout=%b, expected grant=%h sel=%0d valid=%b timeout=%b",
                 i, act.grant, act.sel, act.valid, act.to, ex.grant, ex.sel, ex.valid, ex.to);
      end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] r [9];
    obs_t       x [9];
    obs_t       act, ex;
    do_reset();
    r = '{8'h20, 8'h00, 8'h05, 8'h05, 8'h04, 8'h04, 8'h04, 8'h00, 8'h00};
    x = '{mk(8'h20, 3'd5, 1'b1, 1'b0), mk(8'h00, 3'd5, 1'b0, 1'b0), mk(8'h00, 3'd5, 1'b0, 1'b0),
          mk(8'h01, 3'd0, 1'b1, 1'b0), mk(8'h00, 3'd0, 1'b0, 1'b0), mk(8'h00, 3'd0, 1'b0, 1'b0),
          mk(8'h04, 3'd2, 1'b1, 1'b0), mk(8'h00, 3'd2, 1'b0, 1'b0), mk(8'h00, 3'd2, 1'b0, 1'b0)};
    for (int i = 0; i < 9; i++) begin
      exp_q.push_back(x[i]);
      step(r[i], 1'b1);
      act = observe();
      ex  = exp_q.pop_front();
      checks++;
      if (act !== ex) begin
        errors++;
        $display("FAIL wrap step %0d: got grant=%h sel=%0d valid=%b timeout=%b, expected grant=%h sel=%0d valid=%b timeout=%b",
                 i, act.grant, act.sel, act.valid, act.to, ex.grant, ex.sel, ex.valid, ex.to);
      end
    end
  endtask

  task automatic test_enable();
    logic [7:0] r [10];
    logic       e [10];
    obs_t       x [10];
    obs_t       act, ex;
    do_reset();
    r = '{8'hFF, 8'hFF, 8'hFF, 8'h08, 8'h08, 8'h08, 8'h00, 8'hFF, 8'hFF, 8'hFF};
    e = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    x = '{mk(8'h00, 3'd0, 1'b0, 1'b0), mk(8'h00, 3'd0, 1'b0, 1'b0), mk(8'h00, 3'd0, 1'b0, 1'b0),
          mk(8'h08, 3'd3, 1'b1, 1'b0), mk(8'h08, 3'd3, 1'b1, 1'b0), mk(8'h08, 3'd3, 1'b1, 1'b0),
          mk(8'h00, 3'd3, 1'b0, 1'b0), mk(8'h00, 3'd3, 1'b0, 1'b0), mk(8'h00, 3'd3, 1'b0, 1'b0),
          mk(8'h00, 3'd3, 1'b0, 1'b0)};
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(x[i]);
      step(r[i], e[i]);
      act = observe();
      ex  = exp_q.pop_front();
      checks++;
      if (act !== ex) begin
        errors++;
        $display("FAIL enable step %0d: got grant=%h sel=%0d valid=%b timeout=%b, expected grant=%h sel=%0d valid=%b timeout=%b",
                 i, act.grant, act.sel, act.valid, act.to, ex.grant, ex.sel, ex.valid, ex.to);
      end
    end
  endtask

  task automatic test_async_reset();
    obs_t act, ex;
    do_reset();
    exp_q.push_back(mk(8'h20, 3'd5, 1'b1, 1'b0));
    step(8'h20, 1'b1);
    act = observe();
    ex  = exp_q.pop_front();
    checks++;
    if (act !== ex) begin
      errors++;
      $display("FAIL async_reset_pre: got grant=%h sel=%0d valid=%b, expected grant=%h sel=%0d valid=%b",
               act.grant, act.sel, act.valid, ex.grant, ex.sel, ex.valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    act = observe();
    checks++;
    if (act !== mk(8'h00, 3'd0, 1'b0, 1'b0)) begin
      errors++;
      $display("FAIL async_reset_immediate: got grant=%h sel=%0d valid=%b timeout=%b, expected all zero",
               act.grant, act.sel, act.valid, act.to);
    end
    @(posedge clk);
    @(negedge clk);
    act = observe();
    checks++;
    if (act !== mk(8'h00, 3'd0, 1'b0, 1'b0)) begin
      errors++;
      $display("FAIL async_reset_held: got grant=%h sel=%0d valid=%b timeout=%b, expected all zero",
               act.grant, act.sel, act.valid, act.to);
    end
    rst_n = 1'b1;
    exp_q.push_back(mk(8'h20, 3'd5, 1'b1, 1'b0));
    step(8'h20, 1'b1);
    act = observe();
    ex  = exp_q.pop_front();
    checks++;
    if (act !== ex) begin
      errors++;
      $display("FAIL async_reset_regrant: got grant=%h sel=%0d valid=%b, expected grant=%h sel=%0d valid=%b",
               act.grant, act.sel, act.valid, ex.grant, ex.sel, ex.valid);
    end
  endtask

  initial begin
    test_reset();
    test_single_owner();
    test_timeout_alternate();
    test_release_at_limit();
    test_wrap();
    test_enable();
    test_async_reset();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d leftover entries, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
